// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank: NUM_CH independent PWM channels with run-time programmable
// period/duty, double-buffered so every emitted period is complete.
// Optional feature macro: PWM_PHASE_EN adds a per-channel start phase
// (cfg_phase) that is loaded into the counter on enable rising and on sync.
module pwm_channel_bank #(
    parameter int  NUM_CH         = 4,
    parameter int  CNT_W          = 16,
    parameter int  DEFAULT_PERIOD = 48000,
    parameter int  DEFAULT_DUTY   = 24000,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
`ifdef PWM_PHASE_EN
    input  logic [CNT_W-1:0]  cfg_phase,
`endif
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] period_start
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEF_PER  = cnt_t'(DEFAULT_PERIOD);
    localparam cnt_t DEF_DUTY = cnt_t'(DEFAULT_DUTY);

    // Periods shorter than two cycles are stretched to two.
    function automatic cnt_t eff_period(input cnt_t p);
        return (p < cnt_t'(2)) ? cnt_t'(2) : p;
    endfunction

    cnt_t [NUM_CH-1:0] act_per_q,  act_per_d;
    cnt_t [NUM_CH-1:0] act_duty_q, act_duty_d;
    cnt_t [NUM_CH-1:0] pend_per_q,  pend_per_d;
    cnt_t [NUM_CH-1:0] pend_duty_q, pend_duty_d;
    cnt_t [NUM_CH-1:0] cnt_q, cnt_d;
`ifdef PWM_PHASE_EN
    cnt_t [NUM_CH-1:0] act_ph_q,  act_ph_d;
    cnt_t [NUM_CH-1:0] pend_ph_q, pend_ph_d;
`endif
    logic [NUM_CH-1:0] pend_vld_q, pend_vld_d;
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [NUM_CH-1:0] start_q, start_d;
    logic [NUM_CH-1:0] hit, wrap, copy;

    // A channel holding an unapplied update refuses further writes;
    // out-of-range channel numbers are always accepted (and dropped).
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = !pend_vld_q[i];
        end
    end

    // Per-channel shadow update, counter advance and output decode.
    always_comb begin
        // NOTE: every target gets a default before the loop so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        act_per_d   = act_per_q;
        act_duty_d  = act_duty_q;
        pend_per_d  = pend_per_q;
        pend_duty_d = pend_duty_q;
        pend_vld_d  = pend_vld_q;
        cnt_d       = cnt_q;
        run_d       = ch_en;
        pwm_d       = '0;
        start_d     = '0;
        hit         = '0;
        wrap        = '0;
        copy        = '0;
`ifdef PWM_PHASE_EN
        act_ph_d    = act_ph_q;
        pend_ph_d   = pend_ph_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i]  = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
            wrap[i] = run_q[i] && (cnt_q[i] == eff_period(act_per_q[i]) - cnt_t'(1));
            copy[i] = pend_vld_q[i] && (!ch_en[i] || sync || wrap[i]);

            // Copy uses the old pending value; a same-cycle write refills it.
            if (copy[i]) begin
                act_per_d[i]  = pend_per_q[i];
                act_duty_d[i] = pend_duty_q[i];
`ifdef PWM_PHASE_EN
                act_ph_d[i]   = pend_ph_q[i];
`endif
            end
            if (hit[i]) begin
                pend_per_d[i]  = cfg_period;
                pend_duty_d[i] = cfg_duty;
`ifdef PWM_PHASE_EN
                pend_ph_d[i]   = cfg_phase;
`endif
            end
            pend_vld_d[i] = hit[i] || (pend_vld_q[i] && !copy[i]);

            // Restart (enable rising or sync) starts a new period with the
            // values that will be active for it.
            if (!ch_en[i]) begin
                cnt_d[i] = '0;
            end else if (!run_q[i] || sync) begin
`ifdef PWM_PHASE_EN
                cnt_d[i] = (act_ph_d[i] < eff_period(act_per_d[i])) ? act_ph_d[i] : cnt_t'(0);
`else
                cnt_d[i] = '0;
`endif
            end else if (wrap[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + cnt_t'(1);
            end

            // D=0 never matches; D>=P always matches since cnt <= P-1.
            pwm_d[i]   = ch_en[i] && run_q[i] && (cnt_q[i] < act_duty_q[i]);
            start_d[i] = ch_en[i] && run_q[i] && (cnt_q[i] == cnt_t'(0));
        end
    end

    // State register; configuration shadows return to the power-on defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the config registers are few and must hold defined defaults,
        // so they share the async reset with the control state.
        if (!rst_n) begin
            act_per_q   <= {NUM_CH{DEF_PER}};
            act_duty_q  <= {NUM_CH{DEF_DUTY}};
            pend_per_q  <= {NUM_CH{DEF_PER}};
            pend_duty_q <= {NUM_CH{DEF_DUTY}};
            cnt_q       <= '0;
            pend_vld_q  <= '0;
            run_q       <= '0;
            pwm_q       <= '0;
            start_q     <= '0;
`ifdef PWM_PHASE_EN
            act_ph_q    <= '0;
            pend_ph_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            act_per_q   <= act_per_d;
            act_duty_q  <= act_duty_d;
            pend_per_q  <= pend_per_d;
            pend_duty_q <= pend_duty_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            run_q       <= run_d;
            pwm_q       <= pwm_d;
            start_q     <= start_d;
`ifdef PWM_PHASE_EN
            act_ph_q    <= act_ph_d;
            pend_ph_q   <= pend_ph_d;
`endif
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = start_q;

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Directed bench for pwm_channel_bank (NUM_CH=2, default period/duty).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pwm_channel_bank;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [0:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_duty;
`ifdef PWM_PHASE_EN
    logic [CNT_W-1:0]  cfg_phase;
`endif
    logic [NUM_CH-1:0] pwm_out;
    logic [NUM_CH-1:0] period_start;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pwm_channel_bank #(.NUM_CH(NUM_CH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_en        (ch_en),
        .sync         (sync),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
`ifdef PWM_PHASE_EN
        .cfg_phase    (cfg_phase),
`endif
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    // Present a write request (no checking here).
    task automatic drive_write(input int ch, input int p, input int d, input int ph);
        cfg_valid  = 1'b1;
        cfg_ch     = 1'(ch);
        cfg_period = 16'(p);
        cfg_duty   = 16'(d);
`ifdef PWM_PHASE_EN
        cfg_phase  = 16'(ph);
`else
        if (ph != 0) $display("note: phase %0d ignored in this build", ph);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ch_en = '0; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_period = '0; cfg_duty = '0;
`ifdef PWM_PHASE_EN
        cfg_phase = '0;
`endif
        repeat (3) @(negedge clk);
        vectors++;
        if (pwm_out !== 2'b00) begin miscompares++; $display("FAIL reset_pwm: got %b want 00", pwm_out); end
        vectors++;
        if (period_start !== 2'b00) begin miscompares++; $display("FAIL reset_start: got %b want 00", period_start); end
        vectors++;
        if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (pwm_out !== 2'b00) begin miscompares++; $display("FAIL idle_pwm: got %b want 00", pwm_out); end
    endtask

    // Default 48000/24000 waveform on ch0, with a mid-period rewrite to P=10 D=3.
    task automatic test_default_wave();
        int   bad, first_bad, idx;
        logic ep, es;
        ch_en = 2'b01;
        @(negedge clk);
        vectors++;
        if (pwm_out !== 2'b00) begin miscompares++; $display("FAIL enable_latency: got %b want 00", pwm_out); end
        bad = 0; first_bad = -1;
        for (int s = 1; s <= 48000; s++) begin
            @(negedge clk);
            ep = (s <= 24000);
            es = (s == 1);
            if (pwm_out !== {1'b0, ep} || period_start !== {1'b0, es}) begin
                if (bad == 0) first_bad = s;
                bad++;
            end
            if (s == 30000) begin
                vectors++;
                if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready_before: got %b want 1", cfg_ready); end
                drive_write(0, 10, 3, 0);
            end
            if (s == 30001) begin
                cfg_valid = 1'b0;
                vectors++;
                if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL wr_ready_pending: got %b want 0", cfg_ready); end
            end
            if (s == 47999) begin
                vectors++;
                if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL wr_ready_before_wrap: got %b want 0", cfg_ready); end
            end
            if (s == 48000) begin
                vectors++;
                if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready_after_wrap: got %b want 1", cfg_ready); end
            end
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL default_wave: %0d bad cycles (first %0d), want 0", bad, first_bad); end
        bad = 0; first_bad = -1;
        for (int s = 48001; s <= 48030; s++) begin
            @(negedge clk);
            idx = (s - 48001) % 10;
            ep  = (idx < 3);
            es  = (idx == 0);
            if (pwm_out !== {1'b0, ep} || period_start !== {1'b0, es}) begin
                if (bad == 0) first_bad = s;
                bad++;
            end
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL reprogram_wave: %0d bad cycles (first %0d), want 0", bad, first_bad); end
    endtask

    // Write P=6 D=2 together with sync, then hold a P=4 D=1 write until accepted.
    task automatic test_back_to_back();
        int   acc_t, bad, first_bad, idx, d;
        logic ep, es;
        vectors++;
        if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_first: got %b want 1", cfg_ready); end
        sync = 1'b1;
        drive_write(0, 6, 2, 0);
        acc_t = -1; bad = 0; first_bad = -1;
        for (int t = 0; t <= 28; t++) begin
            @(negedge clk);
            sync = 1'b0;
            if (t == 0) begin cfg_period = 16'd4; cfg_duty = 16'd1; end
            if (t >= 1) begin
                if (t <= 10)      begin idx = t - 1;         d = 3; end
                else if (t <= 16) begin idx = t - 11;        d = 2; end
                else              begin idx = (t - 17) % 4;  d = 1; end
                ep = (idx < d);
                es = (idx == 0);
                if (pwm_out[0] !== ep || period_start[0] !== es) begin
                    if (bad == 0) first_bad = t;
                    bad++;
                end
            end
            if (t == 11) begin
                vectors++;
                if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_second_pending: got %b want 0", cfg_ready); end
            end
            if (t == 16) begin
                vectors++;
                if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_second_applied: got %b want 1", cfg_ready); end
            end
            if (cfg_valid && acc_t >= 0) cfg_valid = 1'b0;
            else if (cfg_valid && cfg_ready) acc_t = t;
        end
        cfg_valid = 1'b0;
        vectors++;
        if (acc_t != 10) begin miscompares++; $display("FAIL b2b_accept_cycle: got %0d want 10", acc_t); end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL b2b_wave: %0d bad cycles (first %0d), want 0", bad, first_bad); end
    endtask

    // Program ch0 while disabled, re-enable, check 16 output cycles.
    task automatic run_case(input int p, input int d, input int pe, input string name);
        int   bad, idx;
        logic ep, es;
        ch_en[0] = 1'b0;
        drive_write(0, p, d, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (cfg_ready !== 1'b1 || pwm_out[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_disabled: ready=%b pwm=%b want ready=1 pwm=0", name, cfg_ready, pwm_out[0]);
        end
        ch_en[0] = 1'b1;
        bad = 0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 0) begin ep = 1'b0; es = 1'b0; end
            else begin
                idx = (k - 1) % pe;
                ep  = (idx < d);
                es  = (idx == 0);
            end
            if (pwm_out[0] !== ep || period_start[0] !== es) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL %s_wave: %0d bad cycles, want 0", name, bad); end
    endtask

    task automatic test_edge_duty();
        run_case(8, 0,   8, "duty0");
        run_case(8, 8,   8, "duty_eq_p");
        run_case(8, 200, 8, "duty_gt_p");
        run_case(1, 1,   2, "period1");
    endtask

    // Two unrelated periods, sync aligns both period_start pulses.
    task automatic test_sync();
        int   bad, i0, i1;
        logic r0, r1;
        logic [1:0] ep, es;
        ch_en = 2'b00;
        drive_write(0, 10, 5, 0);
        @(negedge clk);
        drive_write(1, 7, 2, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        cfg_ch = 1'b0; #1 r0 = cfg_ready;
        cfg_ch = 1'b1; #1 r1 = cfg_ready;
        vectors++;
        if ({r1, r0} !== 2'b11) begin miscompares++; $display("FAIL sync_cfg_applied: got %b want 11", {r1, r0}); end
        ch_en = 2'b11;
        for (int s = 0; s <= 13; s++) begin
            @(negedge clk);
            if (s == 1) begin
                vectors++;
                if (period_start !== 2'b11) begin miscompares++; $display("FAIL enable_start_both: got %b want 11", period_start); end
            end
            if (s == 13) sync = 1'b1;
        end
        @(negedge clk);
        sync = 1'b0;
        vectors++;
        if (period_start !== 2'b00) begin miscompares++; $display("FAIL sync_no_early_start: got %b want 00", period_start); end
        bad = 0;
        for (int t = 1; t <= 21; t++) begin
            @(negedge clk);
            i0 = (t - 1) % 10;
            i1 = (t - 1) % 7;
            ep = {i1 < 2, i0 < 5};
            es = {i1 == 0, i0 == 0};
            if (t == 1) begin
                vectors++;
                if (period_start !== 2'b11) begin miscompares++; $display("FAIL sync_start_aligned: got %b want 11", period_start); end
            end
            if (pwm_out !== ep || period_start !== es) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL sync_wave: %0d bad cycles, want 0", bad); end
    endtask

    // Reset asserted mid-period with a write pending on ch1.
    task automatic test_reset_mid();
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        @(negedge clk);
        drive_write(1, 3, 1, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (pwm_out !== 2'b11 || cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset: pwm=%b ready=%b want pwm=11 ready=0", pwm_out, cfg_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (pwm_out !== 2'b00 || period_start !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: pwm=%b start=%b want 00 00", pwm_out, period_start);
        end
        vectors++;
        if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_mid_pending_dropped: got %b want 1", cfg_ready); end
        ch_en = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (pwm_out !== 2'b00 || cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset: pwm=%b ready=%b want pwm=00 ready=1", pwm_out, cfg_ready);
        end
    endtask

`ifdef PWM_PHASE_EN
    // P=8 D=4 on both channels, phases 0 and 4: complementary outputs.
    task automatic test_phase();
        int bad, i0, i1;
        logic [1:0] ep, es;
        ch_en = 2'b00;
        drive_write(0, 8, 4, 0);
        @(negedge clk);
        drive_write(1, 8, 4, 4);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        ch_en = 2'b11;
        repeat (6) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        bad = 0;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            i0 = (t - 1) % 8;
            i1 = (t + 3) % 8;
            ep = {i1 < 4, i0 < 4};
            es = {i1 == 0, i0 == 0};
            if (pwm_out !== ep || period_start !== es) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL phase_complementary: %0d bad cycles, want 0", bad); end
    endtask
`endif

    initial begin
        test_reset();
        test_default_wave();
        test_back_to_back();
        test_edge_duty();
        test_sync();
        test_reset_mid();
`ifdef PWM_PHASE_EN
        test_phase();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_channel_bank.md
# pwm_channel_bank

Multi-channel programmable PWM generator, the parametrised successor to the fixed 48000-cycle / 50 % switch clock divider. Each of NUM_CH channels has its own period and duty, reprogrammable at run time through a valid/ready config port. Updates are double-buffered so a channel never emits a truncated or glitched period. Outputs drive the PMOD switch lines directly.

## Interface
- NUM_CH, 4: number of independent PWM channels (1..16).
- CNT_W, 16: counter, period and duty width in bits.
- DEFAULT_PERIOD, 48000: period loaded at reset (2.083 kHz at 100 MHz).
- DEFAULT_DUTY, 24000: high time loaded at reset (50 %).

- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- ch_en  input  NUM_CH  per-channel run enable.
- sync  input  1  single-cycle pulse; restarts all enabled channels together.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  config write can be accepted.
- cfg_ch  input  max(1,$clog2(NUM_CH))  target channel.
- cfg_period  input  CNT_W  new period P, in cycles.
- cfg_duty  input  CNT_W  new high time D, in cycles.
- pwm_out  output  NUM_CH  registered PWM outputs.
- period_start  output  NUM_CH  registered one-cycle pulse in cycle 0 of each period.

## Operation
- Per channel: active regs (P, D), pending regs (P, D), pending flag, counter cnt.
- Write accepted when cfg_valid && cfg_ready; stored to pending of cfg_ch, pending flag set. cfg_ch >= NUM_CH: accepted and discarded.
- cfg_ready = !pending_flag[cfg_ch] (combinational on cfg_ch). Write to a channel with an unapplied update stalls until that update is applied.
- Pending → active copy (flag cleared) on: counter wrap, sync, or channel disabled. Write accepted in the same cycle as a copy goes to pending and applies at the next copy event.
- Enabled channel: cnt counts 0..P-1, wraps to 0. Period cycle k: pwm_out high iff k < D.
- Clamping: P < 2 treated as 2. D = 0: constant low. D >= P: constant high. period_start still pulses.
- Disabled channel: cnt held at 0, pwm_out 0, period_start 0, pending applied immediately.
- sync: every enabled channel's cnt forced to cycle 0 of a new period next cycle; disabled channels unaffected.
- Arithmetic unsigned, CNT_W bits; cnt never exceeds P-1, so no overflow.

## Timing
- Reset (async assert, sync release): cnt 0, active = pending = defaults, flags 0, pwm_out 0, period_start 0, cfg_ready 1.
- Enable rising (ch_en sampled 1 at edge N): period cycle 0 appears on outputs at edge N+1.
- pwm_out and period_start are registered, one cycle after the counter state that produces them.
- New P/D take effect from the first output cycle of the period after the copy event.
- Reset mid-period: outputs drop to 0 immediately; pending write discarded.
- sync coincident with wrap: single restart, one period_start pulse.
- sync coincident with enable rising: same behaviour as enable alone.

## Configuration
- PWM_PHASE_EN defined: adds input cfg_phase (CNT_W), shadowed with P/D. On enable rising or sync, cnt loads phase instead of 0 (phase >= P loads 0). period_start still marks cnt==0.
- Undefined: no cfg_phase port; counters always restart at 0.

## Test plan
- Reset defaults, NUM_CH=2, ch_en=2'b01: ch0 high 24000, low 24000, repeating; ch1 stays 0; period_start[0] every 48000 cycles.
- Write ch0 P=10 D=3 mid-period: current 48000 period completes intact, then 3 high / 7 low; cfg_ready low until wrap.
- Back-to-back writes to ch0: second write sees cfg_ready=0 until first applies; second applies one period later.
- Edge duties P=8: D=0 → constant low; D=8 and D=200 → constant high; P=1 behaves as P=2.
- Channels P=10 D=5 and P=7 D=2, sync pulse: both period_start assert the same cycle after sync.
- PWM_PHASE_EN, two channels P=8 D=4, phases 0 and 4, sync: outputs complementary.
